hazard_scoreboard: RTL and testbench



---
 rtl/hazard_pkg.sv | 19 +
 rtl/hz_src_check.sv | 27 ++
 rtl/hazard_scoreboard.sv | 98 +++++++++
 tb/tb_hazard_scoreboard.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared stage constants and the in-flight producer slot type for the hazard scoreboard.
package hazard_pkg;
    localparam int STG_D    = 0;
    localparam int STG_E    = 1;
    localparam int STG_M    = 2;
    localparam int STG_W    = 3;
    localparam int RDY_ALU  = 1;
    localparam int RDY_LOAD = 2;

    // Slot fields are sized for the largest supported AW/SW; narrower values are zero-extended.
    localparam int SLOT_AW  = 8;
    localparam int SLOT_SW  = 4;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] waddr;
        logic [SLOT_SW-1:0] rdy;
    } hz_slot_t;
endpackage

// File: rtl/hz_src_check.sv
// Per-operand RAW check: the youngest in-flight producer of src decides whether D must wait.
import hazard_pkg::*;

module hz_src_check #(
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int SW    = 2
) (
    input  hz_slot_t [DEPTH:1] slots_i,
    input  logic [AW-1:0]      src_i,
    input  logic [SW-1:0]      use_i,
    input  logic               en_i,
    output logic               stall_o
);

    always_comb begin
        stall_o = 1'b0;
        // Walk oldest to youngest so the lowest matching slot has the final say.
        for (int k = DEPTH; k >= 1; k--) begin
            if (slots_i[k].valid && (slots_i[k].waddr == SLOT_AW'(src_i)))
                stall_o = (k + int'(use_i)) <= int'(slots_i[k].rdy);
        end
        if (!en_i || (src_i == '0))
            stall_o = 1'b0;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline interlock: tracks in-flight GPR producers and a mul/div busy timer, raising stall for D.
import hazard_pkg::*;

module hazard_scoreboard #(
    parameter int AW     = 5,
    parameter int DEPTH  = 3,
    parameter int MD_LAT = 5,
    parameter int SW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [SW-1:0] d_rs_use,
    input  logic [SW-1:0] d_rt_use,
    input  logic          d_rs_en,
    input  logic          d_rt_en,
    input  logic          d_wr_en,
    input  logic [AW-1:0] d_wr_addr,
    input  logic [SW-1:0] d_rdy,
    input  logic          d_md_start,
    input  logic          d_md_use,
    input  logic          flush_e,
    output logic          stall,
    output logic [2:0]    stall_cause,
    output logic          md_busy,
    output logic [31:0]   stall_cnt
);

    localparam int MW = $clog2(MD_LAT + 1);

    hz_slot_t [DEPTH:1] slots_q, slots_d;
    hz_slot_t           entry;
    logic [MW-1:0]      md_cnt_q, md_cnt_d;
    logic [31:0]        stall_cnt_q, stall_cnt_d;
    logic               rs_stall, rt_stall;

    hz_src_check #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) u_rs_chk (
        .slots_i (slots_q),
        .src_i   (d_rs),
        .use_i   (d_rs_use),
        .en_i    (d_valid & d_rs_en),
        .stall_o (rs_stall)
    );

    hz_src_check #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) u_rt_chk (
        .slots_i (slots_q),
        .src_i   (d_rt),
        .use_i   (d_rt_use),
        .en_i    (d_valid & d_rt_en),
        .stall_o (rt_stall)
    );

    assign md_busy     = (md_cnt_q != '0);
    assign stall_cause = {d_valid & d_md_use & md_busy, rt_stall, rs_stall};
    assign stall       = |stall_cause;
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        entry       = '0;
        entry.valid = d_valid & d_wr_en & (d_wr_addr != '0) & ~stall & ~flush_e;
        entry.waddr = SLOT_AW'(d_wr_addr);
        entry.rdy   = SLOT_SW'(d_rdy);

        slots_d = slots_q;
        if (en) begin
            for (int k = DEPTH; k >= 2; k--)
                slots_d[k] = slots_q[k-1];
            slots_d[1] = entry;
        end

        // The mul/div timer runs in wall-clock cycles, so only its load waits on en.
        md_cnt_d = md_cnt_q;
        if (d_md_start && d_valid && !stall && !flush_e && en)
            md_cnt_d = MW'(MD_LAT);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - MW'(1);

        stall_cnt_d = stall_cnt_q;
        if (en && stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q     <= '0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            slots_q     <= slots_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: expected interlock outputs are queued per cycle and checked mid-cycle.
import hazard_pkg::*;

module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst, en, d_valid, d_rs_en, d_rt_en, d_wr_en, d_md_start, d_md_use, flush_e;
    logic [4:0]  d_rs, d_rt, d_wr_addr;
    logic [1:0]  d_rs_use, d_rt_use, d_rdy;
    logic        stall, md_busy;
    logic [2:0]  stall_cause;
    logic [31:0] stall_cnt;

    typedef struct {
        string       tag;
        logic        stall;
        logic [2:0]  cause;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_cnt  = 32'd0;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .en(en), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
        .d_rs_en(d_rs_en), .d_rt_en(d_rt_en), .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr),
        .d_rdy(d_rdy), .d_md_start(d_md_start), .d_md_use(d_md_use), .flush_e(flush_e),
        .stall(stall), .stall_cause(stall_cause), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic d_idle();
        d_valid = 0; d_rs = 0; d_rt = 0; d_rs_use = 0; d_rt_use = 0;
        d_rs_en = 0; d_rt_en = 0; d_wr_en = 0; d_wr_addr = 0; d_rdy = 0;
        d_md_start = 0; d_md_use = 0; flush_e = 0;
    endtask

    task automatic d_ins(input logic [4:0] rs, input int rsu, input logic rse,
                         input logic [4:0] rt, input int rtu, input logic rte,
                         input logic we, input logic [4:0] wa, input int rdy,
                         input logic mds, input logic mdu);
        d_valid = 1; d_rs = rs; d_rs_use = 2'(rsu); d_rs_en = rse;
        d_rt = rt; d_rt_use = 2'(rtu); d_rt_en = rte;
        d_wr_en = we; d_wr_addr = wa; d_rdy = 2'(rdy);
        d_md_start = mds; d_md_use = mdu; flush_e = 0;
    endtask

    // One cycle with the currently driven inputs; expectation queued, then checked at negedge.
    task automatic cyc(input string tag, input logic es, input logic [2:0] ec, input logic eb);
        exp_t e;
        exp_t o;
        e.tag = tag; e.stall = es; e.cause = ec; e.busy = eb; e.cnt = m_cnt;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        checks++;
        assert (stall === o.stall) else begin
            errors++; $error("FAIL %s stall obs=%0b exp=%0b", o.tag, stall, o.stall);
        end
        checks++;
        assert (stall_cause === o.cause) else begin
            errors++; $error("FAIL %s stall_cause obs=%b exp=%b", o.tag, stall_cause, o.cause);
        end
        checks++;
        assert (md_busy === o.busy) else begin
            errors++; $error("FAIL %s md_busy obs=%0b exp=%0b", o.tag, md_busy, o.busy);
        end
        checks++;
        assert (stall_cnt === o.cnt) else begin
            errors++; $error("FAIL %s stall_cnt obs=%0d exp=%0d", o.tag, stall_cnt, o.cnt);
        end
        @(posedge clk);
        if (rst) m_cnt = 32'd0;
        else if (en && es && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        #1;
    endtask

    task automatic drain(input int n);
        d_idle();
        for (int i = 0; i < n; i++) cyc("drain", 1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        rst = 1; en = 1; d_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Reset state: a consumer in D with nothing recorded never stalls.
        d_ins(5'd8, STG_D, 1, 5'd9, STG_D, 1, 1, 5'd10, RDY_ALU, 0, 1);
        cyc("rst_state", 1'b0, 3'b000, 1'b0);
        drain(3);

        // lw $8 ; add $9,$8,$1 -> single rs stall.
        d_ins(5'd2, STG_E, 1, 5'd0, STG_E, 0, 1, 5'd8, RDY_LOAD, 0, 0);
        cyc("lw8", 1'b0, 3'b000, 1'b0);
        d_ins(5'd8, STG_E, 1, 5'd1, STG_E, 1, 1, 5'd9, RDY_ALU, 0, 0);
        cyc("ld_use_1", 1'b1, 3'b001, 1'b0);
        cyc("ld_use_2", 1'b0, 3'b000, 1'b0);
        drain(3);

        // addi $8 ; beq $8,$0 -> one stall.
        d_ins(5'd3, STG_E, 1, 5'd0, STG_E, 0, 1, 5'd8, RDY_ALU, 0, 0);
        cyc("addi8", 1'b0, 3'b000, 1'b0);
        d_ins(5'd8, STG_D, 1, 5'd0, STG_D, 1, 0, 5'd0, RDY_ALU, 0, 0);
        cyc("alu_br_1", 1'b1, 3'b001, 1'b0);
        cyc("alu_br_2", 1'b0, 3'b000, 1'b0);
        drain(3);

        // lw $8 ; beq $8,$8 -> two stalls on both operands.
        d_ins(5'd2, STG_E, 1, 5'd0, STG_E, 0, 1, 5'd8, RDY_LOAD, 0, 0);
        cyc("lw8b", 1'b0, 3'b000, 1'b0);
        d_ins(5'd8, STG_D, 1, 5'd8, STG_D, 1, 0, 5'd0, RDY_ALU, 0, 0);
        cyc("ld_br_1", 1'b1, 3'b011, 1'b0);
        cyc("ld_br_2", 1'b1, 3'b011, 1'b0);
        cyc("ld_br_3", 1'b0, 3'b000, 1'b0);
        drain(3);

        // lw $0 ; add $9,$0,$0 -> register 0 is never a producer.
        d_ins(5'd2, STG_E, 1, 5'd0, STG_E, 0, 1, 5'd0, RDY_LOAD, 0, 0);
        cyc("lw0", 1'b0, 3'b000, 1'b0);
        d_ins(5'd0, STG_E, 1, 5'd0, STG_E, 1, 1, 5'd9, RDY_ALU, 0, 0);
        cyc("zero_src", 1'b0, 3'b000, 1'b0);
        drain(3);

        // lw $8 ; sw $8,0($2) -> store data consumed in M, no stall.
        d_ins(5'd2, STG_E, 1, 5'd0, STG_E, 0, 1, 5'd8, RDY_LOAD, 0, 0);
        cyc("lw8c", 1'b0, 3'b000, 1'b0);
        d_ins(5'd2, STG_E, 1, 5'd8, STG_M, 1, 0, 5'd0, RDY_ALU, 0, 0);
        cyc("st_data", 1'b0, 3'b000, 1'b0);
        drain(3);

        // mult then mflo: five busy-stall cycles, mflo proceeds on the sixth.
        d_ins(5'd4, STG_E, 1, 5'd5, STG_E, 1, 0, 5'd0, RDY_ALU, 1, 1);
        cyc("mult", 1'b0, 3'b000, 1'b0);
        d_ins(5'd0, STG_E, 0, 5'd0, STG_E, 0, 1, 5'd10, RDY_ALU, 0, 1);
        for (int i = 1; i <= 5; i++) cyc($sformatf("mflo_%0d", i), 1'b1, 3'b100, 1'b1);
        cyc("mflo_go", 1'b0, 3'b000, 1'b0);
        drain(3);

        // Flushed lw $8 records nothing.
        d_ins(5'd2, STG_E, 1, 5'd0, STG_E, 0, 1, 5'd8, RDY_LOAD, 0, 0);
        flush_e = 1;
        cyc("lw_flush", 1'b0, 3'b000, 1'b0);
        d_ins(5'd8, STG_E, 1, 5'd1, STG_E, 1, 1, 5'd9, RDY_ALU, 0, 0);
        cyc("after_flush", 1'b0, 3'b000, 1'b0);
        drain(3);

        // en=0 with lw in E: stall held, stall_cnt frozen, then resumes.
        d_ins(5'd2, STG_E, 1, 5'd0, STG_E, 0, 1, 5'd8, RDY_LOAD, 0, 0);
        cyc("lw8d", 1'b0, 3'b000, 1'b0);
        d_ins(5'd8, STG_E, 1, 5'd1, STG_E, 1, 1, 5'd9, RDY_ALU, 0, 0);
        en = 0;
        for (int i = 0; i < 3; i++) cyc($sformatf("frozen_%0d", i), 1'b1, 3'b001, 1'b0);
        en = 1;
        cyc("thaw_1", 1'b1, 3'b001, 1'b0);
        cyc("thaw_2", 1'b0, 3'b000, 1'b0);
        drain(3);

        // Reset with md busy and a load in E clears everything next cycle.
        d_ins(5'd4, STG_E, 1, 5'd5, STG_E, 1, 0, 5'd0, RDY_ALU, 1, 1);
        cyc("mult2", 1'b0, 3'b000, 1'b0);
        d_ins(5'd2, STG_E, 1, 5'd0, STG_E, 0, 1, 5'd8, RDY_LOAD, 0, 0);
        cyc("lw8e", 1'b0, 3'b000, 1'b1);
        d_ins(5'd8, STG_E, 1, 5'd1, STG_E, 1, 1, 5'd9, RDY_ALU, 0, 0);
        rst = 1;
        cyc("pre_rst", 1'b1, 3'b001, 1'b1);
        rst = 0;
        cyc("post_rst", 1'b0, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
